// File: rtl/fb_scanout_pkg.sv
// Shared rasterizer definitions: VGA 640x480@60 timing, screen size, pixel/coordinate
// types and the front/back buffer FSM states.
package fb_scanout_pkg;

    localparam int VGA_H_VIS  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;
    localparam int H_TOTAL    = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_VIS  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;
    localparam int V_TOTAL    = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int SCREEN_W = VGA_H_VIS;
    localparam int SCREEN_H = VGA_V_VIS;
    localparam int COORD_W  = 10;

    typedef logic [2:0]         px_color_t;
    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic {
        BUF_SHOW,
        BUF_PENDING
    } buf_state_e;

    // Half-open window test used for the sync pulses.
    function automatic logic in_window(input coord_t val, input coord_t lo, input coord_t hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/fb_scanout_vga_timing.sv
// Pixel-rate divider and raster counters; produces the pixel tick and the
// combinational sync/data-enable levels for the current (h,v) position.
module vga_timing
    import fb_scanout_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int DIV_W   = $clog2(CLK_DIV),
    parameter int H_VIS   = VGA_H_VIS,
    parameter int H_FP    = VGA_H_FP,
    parameter int H_SYNC  = VGA_H_SYNC,
    parameter int H_BP    = VGA_H_BP,
    parameter int V_VIS   = VGA_V_VIS,
    parameter int V_FP    = VGA_V_FP,
    parameter int V_SYNC  = VGA_V_SYNC,
    parameter int V_BP    = VGA_V_BP
) (
    input  logic             clk,
    input  logic             rst,
    output logic             tick,
    output logic [DIV_W-1:0] div,
    output coord_t           h,
    output coord_t           v,
    output logic             hs,
    output logic             vs,
    output logic             de
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam coord_t H_LAST    = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST    = coord_t'(V_TOT - 1);
    localparam coord_t H_VIS_C   = coord_t'(H_VIS);
    localparam coord_t V_VIS_C   = coord_t'(V_VIS);
    localparam coord_t H_SYNC_LO = coord_t'(H_VIS + H_FP);
    localparam coord_t H_SYNC_HI = coord_t'(H_VIS + H_FP + H_SYNC);
    localparam coord_t V_SYNC_LO = coord_t'(V_VIS + V_FP);
    localparam coord_t V_SYNC_HI = coord_t'(V_VIS + V_FP + V_SYNC);

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
            h   <= '0;
            v   <= '0;
        end else begin
            div <= (div == DIV_LAST) ? '0 : div + 1'b1;
            if (tick) begin
                if (h == H_LAST) begin
                    h <= '0;
                    v <= (v == V_LAST) ? '0 : v + 1'b1;
                end else begin
                    h <= h + 1'b1;
                end
            end
        end
    end

    assign tick = (div == '0);
    assign de   = (h < H_VIS_C) && (v < V_VIS_C);
    assign hs   = !in_window(h, H_SYNC_LO, H_SYNC_HI);
    assign vs   = !in_window(v, V_SYNC_LO, V_SYNC_HI);

endmodule

// File: rtl/fb_scanout.sv
// Frame-buffer scanout: one read per visible pixel, color capture, one-pixel
// output alignment, and the front/back buffer handshake (FB_SCANOUT_SWAP_EN).
module fb_scanout
    import fb_scanout_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int READ_LAT = 2,
    parameter int H_VIS    = VGA_H_VIS,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_VIS    = VGA_V_VIS,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raster_done,
    input  logic [2:0] fb_rd_data,
    output logic       fb_rd_en,
    output logic [9:0] fb_rd_x,
    output logic [9:0] fb_rd_y,
    output logic       fb_rd_buf,
    output logic       frame_start,
    output logic [2:0] vga_color,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_de
);

    localparam int DIV_W = $clog2(CLK_DIV);
    // The strobe is registered, so data lands READ_LAT cycles after divider phase 1.
    localparam int CAP_PHASE = (READ_LAT + 1) % CLK_DIV;
    localparam logic [DIV_W-1:0] CAP_DIV = DIV_W'(CAP_PHASE);
    localparam bit     CAP_ON_TICK = (CAP_PHASE == 0);
    localparam coord_t VBLANK_ROW  = coord_t'(V_VIS);

    logic             tick;
    logic [DIV_W-1:0] div;
    coord_t           h;
    coord_t           v;
    logic             hs;
    logic             vs;
    logic             de;

    vga_timing #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (DIV_W),
        .H_VIS   (H_VIS),
        .H_FP    (H_FP),
        .H_SYNC  (H_SYNC),
        .H_BP    (H_BP),
        .V_VIS   (V_VIS),
        .V_FP    (V_FP),
        .V_SYNC  (V_SYNC),
        .V_BP    (V_BP)
    ) u_timing (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .div  (div),
        .h    (h),
        .v    (v),
        .hs   (hs),
        .vs   (vs),
        .de   (de)
    );

    logic      vblank_tick;
    logic      swap_now;
    logic      disp_buf;
    logic      init_q;
    logic      hs_p0;
    logic      vs_p0;
    logic      vld_p0;
    px_color_t color_p1;
    px_color_t cap_color;

    assign vblank_tick = tick && (h == '0) && (v == VBLANK_ROW);
    assign cap_color   = CAP_ON_TICK ? fb_rd_data : color_p1;

    // Stage p0: read strobe and the sync/de levels of the pixel being fetched.
    always_ff @(posedge clk) begin
        if (rst) begin
            fb_rd_en <= 1'b0;
            fb_rd_x  <= '0;
            fb_rd_y  <= '0;
            hs_p0    <= 1'b1;
            vs_p0    <= 1'b1;
            vld_p0   <= 1'b0;
        end else begin
            fb_rd_en <= tick && de;
            if (tick && de) begin
                fb_rd_x <= h;
                fb_rd_y <= v;
            end
            if (tick) begin
                hs_p0  <= hs;
                vs_p0  <= vs;
                vld_p0 <= de;
            end
        end
    end

    // Stage p1: capture returned color; masked downstream when not visible.
    always_ff @(posedge clk) begin
        if (div == CAP_DIV) begin
            color_p1 <= fb_rd_data;
        end
    end

    // Stage p2: all four VGA outputs update together on the next pixel tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_color <= '0;
            vga_hs    <= 1'b1;
            vga_vs    <= 1'b1;
            vga_de    <= 1'b0;
        end else if (tick) begin
            vga_color <= vld_p0 ? cap_color : '0;
            vga_hs    <= hs_p0;
            vga_vs    <= vs_p0;
            vga_de    <= vld_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_q      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            init_q      <= 1'b0;
            frame_start <= init_q | swap_now;
        end
    end

`ifdef FB_SCANOUT_SWAP_EN
    buf_state_e state;
    buf_state_e state_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BUF_SHOW;
            disp_buf  <= 1'b0;
            fb_rd_buf <= 1'b0;
        end else begin
            state    <= state_nxt;
            disp_buf <= disp_buf ^ swap_now;
            if (tick && de) begin
                fb_rd_buf <= disp_buf;
            end
        end
    end

    // A raster_done seen while already pending carries no extra information.
    always_comb begin
        state_nxt = state;
        swap_now  = 1'b0;
        case (state)
            BUF_SHOW: begin
                if (raster_done) begin
                    state_nxt = BUF_PENDING;
                end
            end
            BUF_PENDING: begin
                if (vblank_tick) begin
                    swap_now  = 1'b1;
                    state_nxt = BUF_SHOW;
                end
            end
            default: state_nxt = BUF_SHOW;
        endcase
    end
`else
    logic unused_raster_done;

    assign unused_raster_done = raster_done;
    assign swap_now           = vblank_tick;
    assign disp_buf           = 1'b0;
    assign fb_rd_buf          = disp_buf;
`endif

endmodule

// File: tb/tb_fb_scanout.sv
// Scoreboard bench for fb_scanout on a shrunken raster (15x10 pixels, CLK_DIV=4);
// behaves correctly with or without FB_SCANOUT_SWAP_EN defined.
module tb_fb_scanout;

    localparam int CD  = 4;
    localparam int RL  = 2;
    localparam int HV  = 8;
    localparam int HF  = 2;
    localparam int HS  = 3;
    localparam int HB  = 2;
    localparam int VV  = 6;
    localparam int VF  = 1;
    localparam int VS  = 2;
    localparam int VB  = 1;
    localparam int HT  = HV + HF + HS + HB;
    localparam int VT  = VV + VF + VS + VB;
    localparam int FPX = HT * VT;

    logic       clk = 1'b0;
    logic       rst;
    logic       raster_done;
    logic [2:0] fb_rd_data;
    logic       fb_rd_en;
    logic [9:0] fb_rd_x;
    logic [9:0] fb_rd_y;
    logic       fb_rd_buf;
    logic       frame_start;
    logic [2:0] vga_color;
    logic       vga_hs;
    logic       vga_vs;
    logic       vga_de;

    always #5 clk = ~clk;

    fb_scanout #(
        .CLK_DIV(CD), .READ_LAT(RL),
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .raster_done (raster_done),
        .fb_rd_data  (fb_rd_data),
        .fb_rd_en    (fb_rd_en),
        .fb_rd_x     (fb_rd_x),
        .fb_rd_y     (fb_rd_y),
        .fb_rd_buf   (fb_rd_buf),
        .frame_start (frame_start),
        .vga_color   (vga_color),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_de      (vga_de)
    );

    // Frame-buffer model: color (x+y) mod 8, valid exactly RL cycles after the strobe.
    logic [2:0] mem_p [RL];
    always @(posedge clk) begin
        mem_p[0] <= fb_rd_en ? (fb_rd_x[2:0] + fb_rd_y[2:0]) : 3'd0;
        for (int i = 1; i < RL; i++) mem_p[i] <= mem_p[i-1];
    end
    assign fb_rd_data = mem_p[RL-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [9:0] x; logic [9:0] y; logic b; } rd_t;
    typedef struct { int cyc; logic [6:0] val; } out_t;

    rd_t  rdq [$];
    out_t outq[$];
    int   fsq [$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   de_cnt = 0;
    int   exp_buf_frame [8];
    int   exp_fs_vb     [8];

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Expected {de,hs,vs,color} for pixel index p after reset; p<0 is the reset state.
    function automatic logic [6:0] pix_out(input int p);
        int h, v;
        logic de, hs, vs;
        logic [2:0] c;
        if (p < 0) return {1'b0, 1'b1, 1'b1, 3'd0};
        h  = p % HT;
        v  = (p / HT) % VT;
        de = (h < HV) && (v < VV);
        hs = !((h >= HV + HF) && (h < HV + HF + HS));
        vs = !((v >= VV + VF) && (v < VV + VF + VS));
        c  = de ? 3'((h + v) % 8) : 3'd0;
        return {de, hs, vs, c};
    endfunction

    task automatic push_epoch(input int t0, input int npix, input int limit);
        int c;
        rd_t r;
        out_t o;
        if (t0 + 1 <= limit) fsq.push_back(t0 + 1);
        for (int k = 0; k < 8; k++) begin
            c = t0 + (k * FPX + VV * HT) * CD + 1;
            if (c <= limit && exp_fs_vb[k] != 0) fsq.push_back(c);
        end
        for (int p = -1; p < npix; p++) begin
            if (p >= 0 && (p % HT) < HV && ((p / HT) % VT) < VV) begin
                r.cyc = t0 + 1 + p * CD;
                r.x   = 10'(p % HT);
                r.y   = 10'((p / HT) % VT);
                r.b   = (exp_buf_frame[p / FPX] != 0);
                if (r.cyc <= limit) rdq.push_back(r);
            end
            for (int j = 0; j < CD; j++) begin
                o.cyc = t0 + 1 + (p + 1) * CD + j;
                o.val = pix_out(p);
                if (o.cyc <= limit) outq.push_back(o);
            end
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_done(input int c);
        wait_cyc(c);
        raster_done = 1'b1;
        @(negedge clk);
        raster_done = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        cmp({tag, "_rd"}, {fb_rd_en, fb_rd_x, fb_rd_y, fb_rd_buf}, 22'd0);
        cmp({tag, "_fs"}, 64'(frame_start), 64'd0);
        cmp({tag, "_vga"}, {vga_de, vga_hs, vga_vs, vga_color}, {1'b0, 1'b1, 1'b1, 3'd0});
    endtask

    // Monitor: pops the expected response for whatever the DUT presents this cycle.
    rd_t  mr;
    out_t mo;
    always @(negedge clk) begin
        if (vga_de) de_cnt++;
        if (rdq.size() > 0 && rdq[0].cyc == cyc) begin
            mr = rdq.pop_front();
            cmp("read_strobe", 64'(fb_rd_en), 64'd1);
            if (fb_rd_en) cmp("read_addr", {fb_rd_x, fb_rd_y, fb_rd_buf}, {mr.x, mr.y, mr.b});
        end else if (fb_rd_en) begin
            cmp("read_strobe", 64'(fb_rd_en), 64'd0);
        end
        if (outq.size() > 0 && outq[0].cyc == cyc) begin
            mo = outq.pop_front();
            cmp("vga_out", {vga_de, vga_hs, vga_vs, vga_color}, mo.val);
        end
        if (fsq.size() > 0 && fsq[0] == cyc) begin
            void'(fsq.pop_front());
            cmp("frame_start", 64'(frame_start), 64'd1);
        end else if (frame_start) begin
            cmp("frame_start", 64'(frame_start), 64'd0);
        end
    end

    initial begin
        #(200000 * 10);
        $display("FAIL watchdog: simulation did not finish (%0d compared)", n_cmp);
        $fatal(1, "watchdog");
    end

    int t0;
    int cr;
    int lim;

    initial begin
        rst         = 1'b1;
        raster_done = 1'b0;
`ifdef FB_SCANOUT_SWAP_EN
        exp_buf_frame = '{0, 1, 1, 1, 0, 1, 0, 0};
        exp_fs_vb     = '{1, 0, 0, 1, 1, 0, 0, 0};
`else
        exp_buf_frame = '{0, 0, 0, 0, 0, 0, 0, 0};
        exp_fs_vb     = '{1, 1, 1, 1, 1, 1, 1, 1};
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        t0  = cyc;
        check_reset("reset");
        de_cnt = 0;
        cr = t0 + 800 * CD + 2;              // mid-frame reset at h=5, v=3 of frame 5
        push_epoch(t0, 801, cr);

        pulse_done(t0 + 100);                 // mid-frame: swap at vblank 0
        wait_cyc(t0 + FPX * CD);
        cmp("de_cycles_frame0", de_cnt, HV * VV * CD);
        pulse_done(t0 + (2 * FPX + VV * HT) * CD);   // coincident with vblank 2 tick
        pulse_done(t0 + 1800);                // already pending: ignored
        pulse_done(t0 + 2400);                // swap back at vblank 4

        wait_cyc(cr);
        rst = 1'b1;
        @(negedge clk);
        check_reset("midrst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        t0  = cyc;
        check_reset("rerelease");
        exp_buf_frame = '{0, 0, 0, 0, 0, 0, 0, 0};
`ifdef FB_SCANOUT_SWAP_EN
        exp_fs_vb     = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
        exp_fs_vb     = '{1, 1, 1, 1, 1, 1, 1, 1};
`endif
        lim = t0 + 1 + 160 * CD + CD - 1;
        push_epoch(t0, 160, lim);
        wait_cyc(lim + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
